// File: rtl/counter_core_pkg.sv
// Shared width defaults for the VGA timing/control blocks.
//   PULSE_WIDTH_DEF   : default width of a sync-pulse length field
//   REZ_MAX_WIDTH_DEF : default width of a period field and of a position counter
package counter_core_pkg;

    localparam int unsigned PULSE_WIDTH_DEF   = 8;
    localparam int unsigned REZ_MAX_WIDTH_DEF = 12;

endpackage : counter_core_pkg

// File: rtl/counter_core.sv
// Free-running position counter with an active-low sync strobe, used as the
// horizontal or vertical timing core of a VGA controller.
//
// Ports:
//   Clk          : clock, all state changes on the rising edge
//   Rst          : asynchronous active-high reset
//   Sync_pulse   : sync pulse length in clocks (unsigned)
//   Count_max    : period length in clocks (unsigned); 0 or 1 holds the count at 0
//   Counter_sync : active-low sync strobe, low while CounterP < Sync_pulse (registered)
//   CounterP     : current position, 0 .. Count_max-1 (registered)
module counter_core
    import counter_core_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH   = PULSE_WIDTH_DEF,
    parameter int unsigned REZ_MAX_WIDTH = REZ_MAX_WIDTH_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [PULSE_WIDTH-1:0]   Sync_pulse,
    input  logic [REZ_MAX_WIDTH-1:0] Count_max,
    output logic                     Counter_sync,
    output logic [REZ_MAX_WIDTH-1:0] CounterP
);

    // Common width so the sync compare zero-extends whichever operand is narrower.
    localparam int unsigned CMP_W = (PULSE_WIDTH > REZ_MAX_WIDTH) ? PULSE_WIDTH : REZ_MAX_WIDTH;

    logic [REZ_MAX_WIDTH-1:0] count_q;
    logic [REZ_MAX_WIDTH-1:0] count_d;
    logic [REZ_MAX_WIDTH-1:0] last_pos_c;
    logic                     sync_q;
    logic                     sync_d;

    // Next-state count and strobe; the strobe is derived from count_d so it
    // lines up with CounterP on the same edge.
    always_comb begin
        last_pos_c = '0;
        if (Count_max != '0) begin
            last_pos_c = Count_max - REZ_MAX_WIDTH'(1);
        end

        // >= (not ==) so a period shortened below the current position wraps at once.
        count_d = count_q + REZ_MAX_WIDTH'(1);
        if (count_q >= last_pos_c) begin
            count_d = '0;
        end

        sync_d = (CMP_W'(count_d) >= CMP_W'(Sync_pulse));
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
            sync_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign CounterP     = count_q;
    assign Counter_sync = sync_q;

endmodule : counter_core

// File: tb/tb_counter_core.sv
// Directed self-checking bench for counter_core.
module tb_counter_core;

    localparam int unsigned PW = 8;
    localparam int unsigned RW = 12;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [PW-1:0] Sync_pulse;
    logic [RW-1:0] Count_max;
    logic          Counter_sync;
    logic [RW-1:0] CounterP;

    int n_assert = 0;
    int n_fail   = 0;

    counter_core #(
        .PULSE_WIDTH  (PW),
        .REZ_MAX_WIDTH(RW)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Sync_pulse  (Sync_pulse),
        .Count_max   (Count_max),
        .Counter_sync(Counter_sync),
        .CounterP    (CounterP)
    );

    always #5 Clk = ~Clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    task automatic chk_p(input string tag, input int exp);
        n_assert++;
        assert (CounterP === RW'(exp))
        else begin
            n_fail++;
            $error("FAIL %s: CounterP=%0d expected %0d", tag, CounterP, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic exp);
        n_assert++;
        assert (Counter_sync === exp)
        else begin
            n_fail++;
            $error("FAIL %s: Counter_sync=%b expected %b", tag, Counter_sync, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int    lows;
    int    exp_p8 [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    logic  exp_s3 [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        Rst        = 1'b1;
        Count_max  = RW'(8);
        Sync_pulse = PW'(1);

        // Reset values, then held across a rising edge.
        #1;
        chk_p("reset_p", 0);
        chk_s("reset_s", 1'b1);
        @(negedge Clk);
        chk_p("reset_hold_p", 0);
        chk_s("reset_hold_s", 1'b1);

        // Count_max=8, Sync_pulse=1: 1..7,0,1,2 with strobe low only at 0.
        Rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk_p($sformatf("p8_p[%0d]", i), i % 8);
            chk_s($sformatf("p8_s[%0d]", i), (i % 8 == 0) ? 1'b0 : 1'b1);
        end

        // Count_max=800, Sync_pulse=94 from position 2.
        Count_max  = RW'(800);
        Sync_pulse = PW'(94);
        step(797);
        chk_p("p800_last_p", 799);
        chk_s("p800_last_s", 1'b1);
        step(1);
        chk_p("p800_wrap_p", 0);
        chk_s("p800_wrap_s", 1'b0);
        step(93);
        chk_p("p800_93_p", 93);
        chk_s("p800_93_s", 1'b0);
        step(1);
        chk_p("p800_94_p", 94);
        chk_s("p800_94_s", 1'b1);
        lows = 0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (Counter_sync === 1'b0) lows++;
        end
        chk_n("p800_low_clocks", lows, 94);
        chk_p("p800_period_p", 94);

        // Shrink the period below the current position.
        step(406);
        chk_p("p500_p", 500);
        chk_s("p500_s", 1'b1);
        Count_max  = RW'(8);
        Sync_pulse = PW'(3);
        step(1);
        chk_p("shrink_p", 0);
        chk_s("shrink_s", 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk_p($sformatf("shrink8_p[%0d]", i), exp_p8[i]);
            chk_s($sformatf("shrink8_s[%0d]", i), exp_s3[i]);
        end

        // Asynchronous reset pulse between edges.
        step(5);
        chk_p("pre_async_p", 5);
        chk_s("pre_async_s", 1'b1);
        #2 Rst = 1'b1;
        #1;
        chk_p("async_p", 0);
        chk_s("async_s", 1'b1);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk_p("async_resume_p", 1);
        chk_s("async_resume_s", 1'b0);

        // Reset held over several edges.
        Rst = 1'b1;
        step(2);
        chk_p("held_p", 0);
        chk_s("held_s", 1'b1);
        Rst = 1'b0;
        step(1);
        chk_p("held_release_p", 1);

        // Sync_pulse=0: strobe never asserts.
        Sync_pulse = PW'(0);
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk_s($sformatf("sp0_s[%0d]", i), 1'b1);
        end
        chk_p("sp0_end_p", 1);

        // Sync_pulse beyond the period: strobe never deasserts.
        Sync_pulse = PW'(200);
        Count_max  = RW'(100);
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk_s($sformatf("sp200_s[%0d]", i), 1'b0);
        end
        chk_p("sp200_end_p", 1);

        // Degenerate periods hold the position at 0.
        Count_max = RW'(0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_p($sformatf("cm0_p[%0d]", i), 0);
        end
        Count_max = RW'(1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk_p($sformatf("cm1_p[%0d]", i), 0);
        end
        Count_max = RW'(2);
        step(1);
        chk_p("cm2_a_p", 1);
        step(1);
        chk_p("cm2_b_p", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_counter_core
